// File: rtl/ff_excitation_driver_if.sv
// Purpose: target/excitation/verdict bundle between a stimulus source and ff_excitation_driver.
// Ports: tgt_valid/tgt_ready/tgt_data/mode (target handshake), q_fb (bank readback),
//        d/t/j/k/s/r_out + drv_valid (excitation), done/mismatch (verdict pulses).
interface ff_excitation_driver_if #(
  parameter int WIDTH = 4
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [1:0]       mode;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] d_out;
  logic [WIDTH-1:0] t_out;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic [WIDTH-1:0] s_out;
  logic [WIDTH-1:0] r_out;
  logic             drv_valid;
  logic             done;
  logic             mismatch;

  // master: the side that issues targets and owns the flop bank
  modport master (
    output tgt_valid, tgt_data, mode, q_fb,
    input  tgt_ready, d_out, t_out, j_out, k_out, s_out, r_out,
    input  drv_valid, done, mismatch
  );

  // slave: the excitation driver itself
  modport slave (
    input  tgt_valid, tgt_data, mode, q_fb,
    output tgt_ready, d_out, t_out, j_out, k_out, s_out, r_out,
    output drv_valid, done, mismatch
  );
endinterface

// File: rtl/ff_excitation_driver.sv
// Purpose: turns target next-state words into D/T/JK/SR excitation for an external flop bank,
//          then reads the bank back and reports done/mismatch, counting mismatches (saturating).
// Latency/backpressure: accept at edge N, drive in cycle N..N+1, verdict in N+1..N+2; one target
//          per 3 cycles, tgt_ready low while driving and checking.
// Ports: clk, rst_n (async active-low), bus (slave modport), err_clr (sync clear), err_count.
module ff_excitation_driver #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ff_excitation_driver_if.slave bus,
  input  logic                  err_clr,
  output logic [CNT_W-1:0]      err_count
);

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] tgt_reg;
  logic [1:0]       mode_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tgt_reg  <= '0;
      mode_reg <= MODE_D;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.tgt_valid) begin
        tgt_reg  <= bus.tgt_data;
        mode_reg <= bus.mode;
      end
    end
  end

  // Clear has priority over a coincident mismatch increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (bus.mismatch && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

  always_comb begin
    // Hold encoding: D re-loads the current Q, every other bus is inactive.
    state_nxt     = state;
    bus.tgt_ready = 1'b0;
    bus.drv_valid = 1'b0;
    bus.done      = 1'b0;
    bus.mismatch  = 1'b0;
    bus.d_out     = bus.q_fb;
    bus.t_out     = '0;
    bus.j_out     = '0;
    bus.k_out     = '0;
    bus.s_out     = '0;
    bus.r_out     = '0;

    case (state)
      IDLE: begin
        bus.tgt_ready = 1'b1;
        if (bus.tgt_valid) state_nxt = DRIVE;
      end
      DRIVE: begin
        bus.drv_valid = 1'b1;
        // JK and SR use the same set/reset split; JK don't-cares are driven as 0,
        // which also keeps S and R mutually exclusive per bit.
        case (mode_reg)
          MODE_D:  bus.d_out = tgt_reg;
          MODE_T:  bus.t_out = bus.q_fb ^ tgt_reg;
          MODE_JK: begin
            bus.j_out = tgt_reg & ~bus.q_fb;
            bus.k_out = ~tgt_reg & bus.q_fb;
          end
          MODE_SR: begin
            bus.s_out = tgt_reg & ~bus.q_fb;
            bus.r_out = ~tgt_reg & bus.q_fb;
          end
          default: bus.d_out = bus.q_fb;
        endcase
        state_nxt = CHECK;
      end
      CHECK: begin
        bus.done     = (bus.q_fb == tgt_reg);
        bus.mismatch = (bus.q_fb != tgt_reg);
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ff_excitation_driver.sv
// Purpose: scoreboard bench for ff_excitation_driver with a behavioural flop bank on its outputs.
// Ports: none (top-level bench); drives the interface master side, err_clr and reset.
module tb_ff_excitation_driver;

  localparam int W = 4;

  logic       clk;
  logic       rst_n;
  logic       err_clr;
  logic [7:0] err_count;

  ff_excitation_driver_if #(.WIDTH(W)) bus ();

  ff_excitation_driver #(.WIDTH(W), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural flop bank: any inactive bus is an identity, so the stages can be chained.
  logic [W-1:0] bank_q;
  logic [W-1:0] stuck;
  logic         bank_load;
  logic [W-1:0] load_val;

  assign bus.q_fb = bank_q & ~stuck;

  function automatic logic [W-1:0] bank_next(input logic [W-1:0] d, t, j, k, s, r);
    logic [W-1:0] q1, q2;
    q1 = d ^ t;
    q2 = (j & ~q1) | (~k & q1);
    return s | (~r & q2);
  endfunction

  always @(posedge clk) begin
    if (bank_load) bank_q <= load_val;
    else bank_q <= bank_next(bus.d_out, bus.t_out, bus.j_out, bus.k_out, bus.s_out, bus.r_out);
  end

  // Reference model: per-bit excitation tables, verdict from whether the bank can hold the target.
  typedef struct {
    logic [W-1:0] d, t, j, k, s, r;
    logic         ok;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input logic [1:0] m, input logic [W-1:0] tgt, q, stk);
    exp_t e;
    e.d = q; e.t = '0; e.j = '0; e.k = '0; e.s = '0; e.r = '0;
    for (int i = 0; i < W; i++) begin
      case (m)
        2'd0: e.d[i] = tgt[i];
        2'd1: e.t[i] = (q[i] != tgt[i]);
        2'd2: begin
          if (!q[i] && tgt[i]) e.j[i] = 1'b1;
          if (q[i] && !tgt[i]) e.k[i] = 1'b1;
        end
        default: begin
          if (!q[i] && tgt[i]) e.s[i] = 1'b1;
          if (q[i] && !tgt[i]) e.r[i] = 1'b1;
        end
      endcase
    end
    e.ok = ((tgt & ~stk) == tgt);
    return e;
  endfunction

  // Monitor: compares every cycle; pops the scoreboard on each verdict pulse.
  logic seen_drive = 1'b0;
  logic verdict_mis = 1'b0;
  int   age = 0;
  int   exp_err = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_tgt_ready", bus.tgt_ready, 1);
      chk("rst_drv_valid", bus.drv_valid, 0);
      chk("rst_verdict", {bus.done, bus.mismatch}, 0);
      chk("rst_hold_d", bus.d_out, bus.q_fb);
      chk("rst_hold_other", {bus.t_out, bus.j_out, bus.k_out, bus.s_out, bus.r_out}, 0);
      chk("rst_err_count", err_count, 0);
    end else begin
      chk("err_count", err_count, exp_err);
      chk("s_and_r", bus.s_out & bus.r_out, 0);
      if (bus.drv_valid) begin
        chk("drive_ready_low", bus.tgt_ready, 0);
        chk("drive_once", seen_drive, 0);
        chk("drive_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          chk("d_out", bus.d_out, sb[0].d);
          chk("t_out", bus.t_out, sb[0].t);
          chk("j_out", bus.j_out, sb[0].j);
          chk("k_out", bus.k_out, sb[0].k);
          chk("s_out", bus.s_out, sb[0].s);
          chk("r_out", bus.r_out, sb[0].r);
        end
        seen_drive = 1'b1;
      end else begin
        chk("hold_d", bus.d_out, bus.q_fb);
        chk("hold_other", {bus.t_out, bus.j_out, bus.k_out, bus.s_out, bus.r_out}, 0);
      end
      if (bus.done || bus.mismatch) begin
        chk("verdict_ready_low", bus.tgt_ready, 0);
        chk("verdict_expected", sb.size() > 0, 1);
        chk("verdict_after_drive", seen_drive, 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("done", bus.done, e.ok);
          chk("mismatch", bus.mismatch, !e.ok);
          verdict_mis = !e.ok;
        end
        seen_drive = 1'b0;
        age = 0;
      end else if (sb.size() > 0) begin
        age++;
        if (age > 4) begin
          chk("verdict_timeout", age, 0);
          void'(sb.pop_front());
          seen_drive = 1'b0;
          age = 0;
        end
      end
    end
  end

  // Error-counter model, stepped on the same edge as the DUT counter.
  always @(posedge clk) begin
    if (!rst_n) exp_err = 0;
    else if (err_clr) exp_err = 0;
    else if (verdict_mis && exp_err < 255) exp_err = exp_err + 1;
    verdict_mis = 1'b0;
  end

  task automatic load_bank(input logic [W-1:0] v);
    @(negedge clk);
    bank_load = 1'b1;
    load_val  = v;
    @(negedge clk);
    bank_load = 1'b0;
  endtask

  // Issue one target and return at the negedge after its verdict.
  task automatic do_op(input logic [1:0] m, input logic [W-1:0] tgt);
    int w;
    @(negedge clk);
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = tgt;
    bus.mode      = m;
    w = 0;
    while (!bus.tgt_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", bus.tgt_ready, 1);
    sb.push_back(model(m, tgt, bus.q_fb, stuck));
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = W'($urandom);
    bus.mode      = 2'($urandom);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int last_acc;
    int n_acc;
    rst_n         = 1'b0;
    err_clr       = 1'b0;
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = '0;
    bus.mode      = 2'd0;
    stuck         = '0;
    bank_load     = 1'b1;
    load_val      = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    bank_load = 1'b0;

    // Directed cases
    load_bank(4'b0000); do_op(2'd2, 4'b1010);
    chk("jk_bank", bus.q_fb, 4'b1010);
    load_bank(4'b1010); do_op(2'd1, 4'b0110);
    chk("t_bank", bus.q_fb, 4'b0110);
    load_bank(4'b1100); do_op(2'd3, 4'b1010);
    chk("sr_bank", bus.q_fb, 4'b1010);
    for (int m = 0; m < 4; m++) do_op(2'(m), bus.q_fb);

    // Random targets, occasionally a no-change request
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) do_op(2'($urandom), bus.q_fb);
      else do_op(2'($urandom), W'($urandom));
    end

    // Bit 0 stuck low in D mode: counter increments, then saturates
    load_bank(4'b0000);
    stuck = 4'b0001;
    do_op(2'd0, 4'b0001);
    chk("err_first", err_count, 1);
    for (int i = 0; i < 299; i++) do_op(2'd0, 4'b0001);
    chk("err_saturated", err_count, 255);

    // Clear coinciding with a mismatch
    @(negedge clk);
    bus.tgt_valid = 1'b1; bus.tgt_data = 4'b0001; bus.mode = 2'd0;
    sb.push_back(model(2'd0, 4'b0001, bus.q_fb, stuck));
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clear_wins", err_count, 0);
    stuck = '0;

    // Backpressure: valid held, data changing every cycle
    last_acc = -1;
    n_acc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.tgt_valid = 1'b1;
      bus.tgt_data  = W'($urandom);
      bus.mode      = 2'($urandom);
      if (bus.tgt_ready) begin
        sb.push_back(model(bus.mode, bus.tgt_data, bus.q_fb, stuck));
        if (last_acc >= 0) chk("accept_spacing", c - last_acc, 3);
        last_acc = c;
        n_acc++;
      end
    end
    chk("accept_count", n_acc > 10, 1);
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during DRIVE abandons the operation
    @(negedge clk);
    bus.tgt_valid = 1'b1; bus.tgt_data = ~bus.q_fb; bus.mode = 2'd1;
    sb.push_back(model(2'd1, ~bus.q_fb, bus.q_fb, stuck));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.tgt_valid = 1'b0;
    sb.delete();
    seen_drive = 1'b0;
    age = 0;
    repeat (3) @(negedge clk);
    chk("mid_rst_ready", bus.tgt_ready, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    do_op(2'd2, W'($urandom));
    do_op(2'd3, W'($urandom));

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    chk("drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
